bsg_gateway_clk_monitor: RTL and testbench
==========================================

Name: bsg_gateway_clk_monitor

Overview:
- Receive-side checker for the gateway clock tree.
- Samples one forwarded or looped-back clock (e.g. ext_core_clk, tag_tck) and a PLL/DCM locked flag, both asynchronous to the reference clock.
- Debounces lock, measures the sampled clock's frequency as rising edges per fixed reference window, and flags loss of lock.
- Sits beside the clock generator; results feed MicroBlaze status registers.

Parameters:
- window_cycles_p, 65536, reference cycles per measurement window (>=4).
- count_width_p, 16, width of edge count; count saturates at all-ones.
- sync_stages_p, 2, synchronizer flops for each async input (>=2).
- lock_debounce_p, 256, consecutive synced-high cycles before lock is considered stable.
- min_count_p, 0, lower bound for in-range check (inclusive).
- max_count_p, 65535, upper bound for in-range check (inclusive).

Ports:
- clk_i  in  1  reference clock; must be more than 2x the monitored clock frequency.
- reset_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  measurement enable.
- clear_i  in  1  clears lock_lost_o.
- mon_clk_i  in  1  monitored clock, asynchronous, sampled as data.
- locked_i  in  1  PLL/DCM locked flag, asynchronous.
- count_o  out  count_width_p  last completed window edge count.
- count_v_o  out  1  one-cycle pulse: count_o updated this cycle.
- in_range_o  out  1  min_count_p <= count_o <= max_count_p.
- locked_stable_o  out  1  debounced lock.
- lock_lost_o  out  1  sticky: locked_stable_o has fallen since last clear.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Synchronizers:
  - mon_clk_i and locked_i each pass through sync_stages_p flops.
  - edge = synced mon high AND previous synced mon low.
- Lock debounce:
  - Counter increments while synced locked is high.
  - locked_stable_o rises on the cycle the counter reaches lock_debounce_p; the counter then holds.
  - Synced locked low: counter clears and locked_stable_o drops the same cycle.
- lock_lost_o:
  - Sets the cycle after locked_stable_o goes 1->0.
  - clear_i clears it.
  - Set and clear in the same cycle: set wins.
- FSM states IDLE, WAIT_LOCK, MEASURE, REPORT:
  - IDLE -> WAIT_LOCK when en_i=1.
  - WAIT_LOCK -> MEASURE when locked_stable_o=1. Window counter and edge counter load 0.
  - MEASURE:
    - Window counter increments each cycle; edge counter increments on each edge, saturating.
    - On window counter = window_cycles_p-1: the final edge (if any) is included, the result is latched, and the FSM goes to REPORT.
  - REPORT (one cycle): count_o and in_range_o update, count_v_o=1, then back to MEASURE with counters reset. Windows are back-to-back with no gap.
  - Edges arriving during the REPORT cycle count toward the next window.
  - en_i=0 in any state -> IDLE next cycle.
  - locked_stable_o=0 in MEASURE or REPORT -> WAIT_LOCK.
  - Either abort discards the partial window: no count_v_o, and count_o keeps its previous value.
- Latency:
  - count_v_o fires exactly window_cycles_p+1 cycles after MEASURE entry for the first window.
  - Subsequent windows fire every window_cycles_p+1 cycles.
- Width rules:
  - Window counter is $clog2(window_cycles_p) bits.
  - in_range compare is unsigned, at count_width_p.
- Asynchronous reset mid-window: all state returns to reset values immediately.

Decomposition:
- Package bsg_gateway_clk_monitor_pkg holds:
  - the state enum typedef (bsg_gateway_clk_monitor_state_e);
  - a constant for the window counter width function.
- One sub-module, bsg_gateway_sync_edge:
  - parameterized synchronizer chain plus rising-edge pulse;
  - instantiated twice (mon_clk_i, locked_i), with the edge output unused for lock.

Test Plan:
- window_cycles_p=100, lock_debounce_p=8. locked_i high, en_i=1, mon_clk_i period 10 clk_i -> count_v_o every 101 cycles, count_o=10 each window.
- count_width_p=4, mon_clk_i period 4 clk_i, window 100 -> count_o=15 (saturated). With max_count_p=14 -> in_range_o=0.
- locked_i pulses high for 5 cycles, then low, with lock_debounce_p=8 -> locked_stable_o stays 0, no count_v_o, lock_lost_o stays 0.
- Lock stable, drop locked_i at window cycle 50:
  - locked_stable_o falls after sync latency;
  - no count_v_o for the aborted window;
  - count_o keeps its prior value;
  - lock_lost_o=1 until clear_i.
  - Raise clear_i in the same cycle a new loss is detected -> lock_lost_o stays 1.
- en_i deasserted at window cycle 30, reasserted 10 cycles later -> first count_v_o exactly 101 cycles after MEASURE re-entry, count_o=10.
- Assert reset_n_i=0 mid-window -> all outputs 0 immediately, FSM IDLE. After release, full debounce is required before measuring.

Source files
------------

// File: rtl/bsg_gateway_clk_monitor_pkg.sv
// Shared types and helpers for the gateway clock monitor.
// Holds the FSM state encoding and the window-counter sizing rule.
package bsg_gateway_clk_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOCK = 2'd1,
    MEASURE   = 2'd2,
    REPORT    = 2'd3
  } bsg_gateway_clk_monitor_state_e;

  // Bits needed to count 0 .. n-1 reference cycles of a window.
  function automatic int clk_mon_win_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int clk_mon_default_win_w_c = clk_mon_win_width(65536);

endpackage

// File: rtl/bsg_gateway_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with a rising-edge pulse
// derived from the synchronized value.
module bsg_gateway_sync_edge #(
  parameter int unsigned stages_p = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic data_i,
  output logic sync_o,
  output logic edge_o
);

  logic [stages_p-1:0] chain_q, chain_d;
  logic                prev_q, prev_d;

  always_comb begin
    chain_d = {chain_q[stages_p-2:0], data_i};
    prev_d  = chain_q[stages_p-1];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = chain_q[stages_p-1];
  assign edge_o = chain_q[stages_p-1] & ~prev_q;

endmodule

// File: rtl/bsg_gateway_clk_monitor.sv
// Gateway clock checker: debounces PLL lock, counts monitored-clock rising
// edges per fixed reference window, and keeps a sticky loss-of-lock flag.
module bsg_gateway_clk_monitor #(
  parameter int unsigned window_cycles_p = 65536,
  parameter int unsigned count_width_p   = 16,
  parameter int unsigned sync_stages_p   = 2,
  parameter int unsigned lock_debounce_p = 256,
  parameter int unsigned min_count_p     = 0,
  parameter int unsigned max_count_p     = 65535
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     en_i,
  input  logic                     clear_i,
  input  logic                     mon_clk_i,
  input  logic                     locked_i,
  output logic [count_width_p-1:0] count_o,
  output logic                     count_v_o,
  output logic                     in_range_o,
  output logic                     locked_stable_o,
  output logic                     lock_lost_o
);

  import bsg_gateway_clk_monitor_pkg::*;

  localparam int win_w_lp = clk_mon_win_width(window_cycles_p);
  localparam int deb_w_lp = $clog2(lock_debounce_p + 1);
  localparam logic [win_w_lp-1:0]      win_last_lp = win_w_lp'(window_cycles_p - 1);
  localparam logic [deb_w_lp-1:0]      deb_max_lp  = deb_w_lp'(lock_debounce_p);
  localparam logic [count_width_p-1:0] min_lp      = count_width_p'(min_count_p);
  localparam logic [count_width_p-1:0] max_lp      = count_width_p'(max_count_p);

  logic mon_edge, mon_sync_unused;
  logic lock_sync, lock_edge_unused;

  bsg_gateway_sync_edge #(.stages_p(sync_stages_p)) u_mon_sync (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .data_i   (mon_clk_i),
    .sync_o   (mon_sync_unused),
    .edge_o   (mon_edge)
  );

  bsg_gateway_sync_edge #(.stages_p(sync_stages_p)) u_lock_sync (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .data_i   (locked_i),
    .sync_o   (lock_sync),
    .edge_o   (lock_edge_unused)
  );

  bsg_gateway_clk_monitor_state_e state_q, state_d;
  logic [deb_w_lp-1:0]      deb_cnt_q, deb_cnt_d;
  logic                     stable_q, stable_d;
  logic                     fall_q, fall_d;
  logic                     lost_q, lost_d;
  logic [win_w_lp-1:0]      win_q, win_d;
  logic [count_width_p-1:0] edge_cnt_q, edge_cnt_d, edge_inc;
  logic [count_width_p-1:0] result_q, result_d;
  logic [count_width_p-1:0] count_q, count_d;
  logic                     count_v_q, count_v_d;
  logic                     in_range_q, in_range_d;
  logic                     lo_ok, hi_ok;

  // Trivial bounds skip the compare entirely.
  if (min_lp == '0) begin : g_lo_any
    assign lo_ok = 1'b1;
  end else begin : g_lo_cmp
    assign lo_ok = (result_q >= min_lp);
  end

  if (max_lp == '1) begin : g_hi_any
    assign hi_ok = 1'b1;
  end else begin : g_hi_cmp
    assign hi_ok = (result_q <= max_lp);
  end

  always_comb begin
    deb_cnt_d = deb_cnt_q;
    if (!lock_sync)
      deb_cnt_d = '0;
    else if (deb_cnt_q != deb_max_lp)
      deb_cnt_d = deb_cnt_q + 1'b1;
    stable_d = (deb_cnt_d == deb_max_lp);
    // Loss is flagged one cycle after the stable flag falls; a new loss beats clear.
    fall_d   = stable_q & ~stable_d;
    lost_d   = fall_q | (lost_q & ~clear_i);
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    edge_cnt_d = edge_cnt_q;
    result_d   = result_q;
    count_d    = count_q;
    count_v_d  = 1'b0;
    in_range_d = in_range_q;
    edge_inc   = (mon_edge && (edge_cnt_q != '1)) ? edge_cnt_q + 1'b1 : edge_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (en_i) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (!en_i) state_d = IDLE;
        else if (stable_q) begin
          state_d    = MEASURE;
          win_d      = '0;
          edge_cnt_d = '0;
        end
      end
      MEASURE: begin
        if (!en_i) state_d = IDLE;
        else if (!stable_q) state_d = WAIT_LOCK;
        else if (win_q == win_last_lp) begin
          result_d   = edge_inc;
          win_d      = '0;
          edge_cnt_d = edge_inc;
          state_d    = REPORT;
        end else begin
          win_d      = win_q + 1'b1;
          edge_cnt_d = edge_inc;
        end
      end
      REPORT: begin
        if (!en_i) state_d = IDLE;
        else if (!stable_q) state_d = WAIT_LOCK;
        else begin
          count_d    = result_q;
          count_v_d  = 1'b1;
          in_range_d = lo_ok & hi_ok;
          win_d      = '0;
          // An edge seen during REPORT opens the next window.
          edge_cnt_d = {{(count_width_p-1){1'b0}}, mon_edge};
          state_d    = MEASURE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      deb_cnt_q  <= '0;
      stable_q   <= 1'b0;
      fall_q     <= 1'b0;
      lost_q     <= 1'b0;
      win_q      <= '0;
      edge_cnt_q <= '0;
      result_q   <= '0;
      count_q    <= '0;
      count_v_q  <= 1'b0;
      in_range_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      stable_q   <= stable_d;
      fall_q     <= fall_d;
      lost_q     <= lost_d;
      win_q      <= win_d;
      edge_cnt_q <= edge_cnt_d;
      result_q   <= result_d;
      count_q    <= count_d;
      count_v_q  <= count_v_d;
      in_range_q <= in_range_d;
    end
  end

  assign count_o         = count_q;
  assign count_v_o       = count_v_q;
  assign in_range_o      = in_range_q;
  assign locked_stable_o = stable_q;
  assign lock_lost_o     = lost_q;

endmodule

// File: tb/tb_bsg_gateway_clk_monitor.sv
// Directed-plus-random bench for the gateway clock monitor: two instances
// (wide and 4-bit saturating count) share stimulus; windows are scored from recorded input edges.
module tb_bsg_gateway_clk_monitor;
  localparam int S = 2;
  localparam int W = 100;
  localparam int D = 8;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  logic en_i = 1'b0;
  logic clear_i = 1'b0;
  logic mon_clk_i = 1'b0;
  logic locked_i = 1'b0;
  logic [15:0] count_a;
  logic [3:0]  count_b;
  logic v_a, v_b, ir_a, ir_b, st_a, st_b, ll_a, ll_b;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int mon_period = 0;
  int rises[$];

  bsg_gateway_clk_monitor #(
    .window_cycles_p(W), .count_width_p(16), .sync_stages_p(S),
    .lock_debounce_p(D), .min_count_p(9), .max_count_p(11)
  ) dut_a (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(en_i), .clear_i(clear_i),
    .mon_clk_i(mon_clk_i), .locked_i(locked_i), .count_o(count_a),
    .count_v_o(v_a), .in_range_o(ir_a), .locked_stable_o(st_a), .lock_lost_o(ll_a)
  );

  bsg_gateway_clk_monitor #(
    .window_cycles_p(W), .count_width_p(4), .sync_stages_p(S),
    .lock_debounce_p(D), .min_count_p(0), .max_count_p(14)
  ) dut_b (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(en_i), .clear_i(clear_i),
    .mon_clk_i(mon_clk_i), .locked_i(locked_i), .count_o(count_b),
    .count_v_o(v_b), .in_range_o(ir_b), .locked_stable_o(st_b), .lock_lost_o(ll_b)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitored clock: square wave of mon_period reference cycles, random phase on each change.
  initial begin : mon_drv
    int ph;
    int last_p;
    ph = 0;
    last_p = 0;
    forever begin
      @(negedge clk_i);
      if (mon_period > 0) begin
        if (mon_period != last_p) begin
          last_p = mon_period;
          ph = $urandom_range(0, mon_period - 1);
        end else begin
          ph = (ph + 1) % mon_period;
        end
        if ((ph < mon_period / 2) && !mon_clk_i) rises.push_back(cyc);
        mon_clk_i = (ph < mon_period / 2);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 40000", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_i);
  endtask

  // Input rise driven in cycle r is counted by the edge logic at posedge r+S+1.
  function automatic int model_count(input int lo, input int hi, input int cw);
    int n;
    n = 0;
    foreach (rises[i])
      if ((rises[i] + S + 1 >= lo) && (rises[i] + S + 1 <= hi)) n++;
    if (n > (1 << cw) - 1) n = (1 << cw) - 1;
    return n;
  endfunction

  // First window after MEASURE entry covers W cycles; back-to-back windows
  // also own the REPORT cycle, so they cover W+1.
  task automatic expect_pulse(input string tag, input int exp_t, input bit first,
                              output int t, output int a);
    int lo, b;
    t = -1;
    a = 0;
    for (int k = 0; k < 3 * W && t < 0; k++) begin
      @(negedge clk_i);
      if (v_a === 1'b1) t = cyc;
    end
    chk({tag, "_time"}, t, exp_t);
    if (t >= 0) begin
      lo = first ? t - W : t - W - 1;
      a = model_count(lo, t - 1, 16);
      b = model_count(lo, t - 1, 4);
      chk({tag, "_cnt_a"}, 32'(count_a), a);
      chk({tag, "_rng_a"}, 32'(ir_a), (a >= 9 && a <= 11) ? 1 : 0);
      chk({tag, "_v_b"}, 32'(v_b), 1);
      chk({tag, "_cnt_b"}, 32'(count_b), b);
      chk({tag, "_rng_b"}, 32'(ir_b), (b <= 14) ? 1 : 0);
      @(negedge clk_i);
      chk({tag, "_v_drop"}, 32'(v_a), 0);
    end
  endtask

  initial begin : stim
    int n, m, p, a, last_a, nv;
    bit seen_st, seen_v, seen_ll;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_cnt_a", 32'(count_a), 0);
    chk("rst_v_a", 32'(v_a), 0);
    chk("rst_rng_a", 32'(ir_a), 0);
    chk("rst_st_a", 32'(st_a), 0);
    chk("rst_ll_a", 32'(ll_a), 0);
    chk("rst_cnt_b", 32'(count_b), 0);
    chk("rst_v_b", 32'(v_b), 0);
    reset_n_i = 1'b1;
    en_i = 1'b1;
    mon_period = 10;

    // Short lock pulse must never reach stable
    repeat (5) @(negedge clk_i);
    locked_i = 1'b1;
    seen_st = 0; seen_v = 0; seen_ll = 0;
    for (int k = 0; k < 65; k++) begin
      @(negedge clk_i);
      if (k == 4) locked_i = 1'b0;
      if (st_a) seen_st = 1;
      if (v_a) seen_v = 1;
      if (ll_a) seen_ll = 1;
    end
    chk("short_lock_stable", 32'(seen_st), 0);
    chk("short_lock_no_v", 32'(seen_v), 0);
    chk("short_lock_no_lost", 32'(seen_ll), 0);

    // Lock and measure back-to-back windows at period 10
    n = cyc;
    locked_i = 1'b1;
    expect_pulse("win0", n + S + D + W + 2, 1'b1, p, a);
    for (int k = 0; k < 3; k++) expect_pulse("win_p10", p + W + 1, 1'b0, p, a);

    // Saturation on the 4-bit instance
    mon_period = 4;
    for (int k = 0; k < 3; k++) expect_pulse("win_p4", p + W + 1, 1'b0, p, a);

    // Random monitored periods
    for (int k = 0; k < 3; k++) begin
      mon_period = $urandom_range(3, 40);
      expect_pulse("win_rand", p + W + 1, 1'b0, p, a);
    end
    mon_period = 10;
    expect_pulse("win_back10", p + W + 1, 1'b0, p, a);
    expect_pulse("win_clean10", p + W + 1, 1'b0, p, last_a);

    // Lock drop mid-window
    wait_until(p + 50);
    n = cyc;
    locked_i = 1'b0;
    wait_until(n + S);
    chk("drop_st_hold", 32'(st_a), 1);
    @(negedge clk_i);
    chk("drop_st_fall", 32'(st_a), 0);
    chk("drop_ll_pre", 32'(ll_a), 0);
    @(negedge clk_i);
    chk("drop_ll_set", 32'(ll_a), 1);
    nv = 0;
    repeat (150) begin
      @(negedge clk_i);
      if (v_a) nv++;
    end
    chk("drop_no_v", nv, 0);
    chk("drop_cnt_kept", 32'(count_a), last_a);
    chk("drop_ll_sticky", 32'(ll_a), 1);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk("drop_clear", 32'(ll_a), 0);

    // New loss and clear in the same cycle: set wins
    n = cyc;
    locked_i = 1'b1;
    wait_until(n + S + D + 5);
    chk("relock_st", 32'(st_a), 1);
    n = cyc;
    locked_i = 1'b0;
    wait_until(n + S + 1);
    chk("coll_ll_pre", 32'(ll_a), 0);
    clear_i = 1'b1;
    @(negedge clk_i);
    chk("coll_set_wins", 32'(ll_a), 1);
    clear_i = 1'b0;
    @(negedge clk_i);
    chk("coll_ll_hold", 32'(ll_a), 1);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk("coll_clear", 32'(ll_a), 0);

    // Enable dropped mid-window, then restored
    n = cyc;
    locked_i = 1'b1;
    expect_pulse("relock_win", n + S + D + W + 2, 1'b1, p, a);
    wait_until(p + 30);
    en_i = 1'b0;
    repeat (10) @(negedge clk_i);
    m = cyc;
    en_i = 1'b1;
    expect_pulse("en_reentry", m + W + 3, 1'b1, p, a);
    chk("en_reentry_cnt10", 32'(a), 10);

    // Asynchronous reset mid-window
    wait_until(p + 40);
    #1 reset_n_i = 1'b0;
    #1;
    chk("arst_cnt_a", 32'(count_a), 0);
    chk("arst_rng_a", 32'(ir_a), 0);
    chk("arst_st_a", 32'(st_a), 0);
    chk("arst_ll_a", 32'(ll_a), 0);
    chk("arst_cnt_b", 32'(count_b), 0);
    chk("arst_st_b", 32'(st_b), 0);
    repeat (3) @(negedge clk_i);
    n = cyc;
    reset_n_i = 1'b1;
    wait_until(n + S + D - 1);
    chk("arst_deb_low", 32'(st_a), 0);
    @(negedge clk_i);
    chk("arst_deb_high", 32'(st_a), 1);
    expect_pulse("arst_win", n + S + D + W + 2, 1'b1, p, a);
    chk("arst_ll_b", 32'(ll_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
